// File: rtl/switch_read_port_pkg.sv
// Shared io definitions: memory-mapped load addresses, debounce state
// encoding and status-word layout for the board input/output peripherals.
package switch_read_port_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 16;
    localparam int unsigned CNT_W  = 20;

    // Existing write-side peripherals, kept here so the whole io map lives in one place
    localparam logic [ADDR_W-1:0] DISPLAY_ADDR = 32'hffff_fff0;
    localparam logic [ADDR_W-1:0] LED_ADDR     = 32'hffff_ffc2;

    // Read-side switch peripheral
    localparam logic [ADDR_W-1:0] DATA_ADDR    = 32'hffff_ffc0;
    localparam logic [ADDR_W-1:0] STATUS_ADDR  = 32'hffff_ffc4;
    localparam logic [ADDR_W-1:0] LIVE_ADDR    = 32'hffff_ffc8;

    // Debounce FSM encoding
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Status word bit positions
    localparam int unsigned PENDING_BIT = 0;
    localparam int unsigned OVERRUN_BIT = 1;

    // Zero-extend a switch-width value onto the data bus
    function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] v);
        return {{(DATA_W-SW_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/switch_read_port_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a debounce FSM that
// emits exactly one registered capture pulse per accepted press.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_i      raw, asynchronous, bouncy button (active-high)
//   capture_o  one-cycle pulse when a press has been stable long enough
module btn_debounce
    import switch_read_port_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic capture_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - CNT_W'(1);

    logic             btn_meta_q;
    logic             btn_s_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture_q, capture_d;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_inc;

    // Synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_i;
            btn_s_q    <= btn_meta_q;
        end
    end

    assign cnt_done = (cnt_q == CNT_LAST);
    // Saturating increment: the counter never wraps
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_s_q) state_d = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!btn_s_q)     state_d = ST_IDLE;
                else if (cnt_done) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!btn_s_q) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (btn_s_q)       state_d = ST_HELD;
                else if (cnt_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / counter logic; counter is cleared whenever a wait state is about to be entered
    always_comb begin
        cnt_d     = cnt_q;
        capture_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_PRESS_WAIT: begin
                if (btn_s_q) begin
                    if (cnt_done) capture_d = 1'b1;
                    else          cnt_d     = cnt_inc;
                end
            end
            ST_HELD: begin
                cnt_d = '0;
            end
            ST_RELEASE_WAIT: begin
                if (!btn_s_q && !cnt_done) cnt_d = cnt_inc;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Counter and capture pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            capture_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            capture_q <= capture_d;
        end
    end

    assign capture_o = capture_q;

endmodule

// File: rtl/switch_read_port.sv
// CPU-facing switch read port: synchronises the board switches, latches a
// snapshot on each debounced confirmation press and serves memory-mapped
// loads (snapshot, status flags, live switches) with one cycle of latency.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   switchInput   raw board switches (asynchronous)
//   confirmation  raw confirmation button (asynchronous, bouncy)
//   ioRead        CPU load strobe, address  CPU load address
//   dataIOInput   registered read data, readValid  response strobe
//   pending       unread snapshot present, overrun  snapshot lost (sticky)
module switch_read_port
    import switch_read_port_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   switchInput,
    input  logic              confirmation,
    input  logic              ioRead,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataIOInput,
    output logic              readValid,
    output logic              pending,
    output logic              overrun
);

    logic [SW_W-1:0]   sw_meta_q;
    logic [SW_W-1:0]   sw_s_q;
    logic [SW_W-1:0]   snapshot_q, snapshot_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              capture;
    logic              rd_data, rd_status, rd_live;
    logic [DATA_W-1:0] status_word;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (confirmation),
        .capture_o(capture)
    );

    // Synchroniser for the switch bank
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= switchInput;
            sw_s_q    <= sw_meta_q;
        end
    end

    assign rd_data   = ioRead && (address == DATA_ADDR);
    assign rd_status = ioRead && (address == STATUS_ADDR);
    assign rd_live   = ioRead && (address == LIVE_ADDR);

    // Status word reflects flag values before any clear this cycle
    always_comb begin
        status_word              = '0;
        status_word[PENDING_BIT] = pending_q;
        status_word[OVERRUN_BIT] = overrun_q;
    end

    // Snapshot and flag update; a capture's set always wins over a read's clear.
    // A capture only overruns if the old snapshot is not being consumed this cycle.
    always_comb begin
        snapshot_d = snapshot_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q && !rd_status;
        if (rd_data) pending_d = 1'b0;
        if (capture) begin
            snapshot_d = sw_s_q;
            pending_d  = 1'b1;
            if (pending_q && !rd_data) overrun_d = 1'b1;
        end
    end

    // Read mux; unmapped addresses produce no response
    always_comb begin
        rdata_d  = '0;
        rvalid_d = rd_data || rd_status || rd_live;
        if (rd_data)        rdata_d = zext_sw(snapshot_q);
        else if (rd_status) rdata_d = status_word;
        else if (rd_live)   rdata_d = zext_sw(sw_s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            snapshot_q <= snapshot_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign dataIOInput = rdata_q;
    assign readValid   = rvalid_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_switch_read_port.sv
// Directed self-checking bench for switch_read_port with a short debounce window.
module tb_switch_read_port;
    import switch_read_port_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] switchInput;
    logic        confirmation;
    logic        ioRead;
    logic [31:0] address;
    logic [31:0] dataIOInput;
    logic        readValid;
    logic        pending;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic pend_prev = 1'b0;

    switch_read_port #(
        .DEBOUNCE_CYCLES(20'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switchInput (switchInput),
        .confirmation(confirmation),
        .ioRead      (ioRead),
        .address     (address),
        .dataIOInput (dataIOInput),
        .readValid   (readValid),
        .pending     (pending),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of pending to detect duplicate or missing captures
    always @(negedge clk) begin
        if (pending === 1'b1 && pend_prev === 1'b0) rises++;
        pend_prev = pending;
    end

    // Advance n clock edges, then settle just after the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
        ioRead  = 1'b1;
        address = a;
        tick(1);
        ioRead  = 1'b0;
        address = 32'h0;
        v = readValid;
        d = dataIOInput;
    endtask

    // Full press: switches settle, button held 10 cycles, released 10 cycles
    task automatic press(input logic [15:0] sw);
        switchInput = sw;
        tick(2);
        confirmation = 1'b1;
        tick(10);
        confirmation = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        logic v;
        logic [31:0] d;
        rst = 1'b1;
        ioRead = 1'b1;
        address = LIVE_ADDR;
        tick(3);
        rst = 1'b0;
        ioRead = 1'b0;
        address = 32'h0;
        checks++;
        if (readValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", readValid); end
        checks++;
        if (dataIOInput !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", dataIOInput); end
        checks++;
        if ({pending, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {pending, overrun}); end
        do_read(STATUS_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reset_status_read: got v=%b d=%h expected v=1 d=00000000", v, d); end
        do_read(DATA_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reset_data_read: got v=%b d=%h expected v=1 d=00000000", v, d); end
        tick(1);
        checks++;
        if (readValid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b expected 0", readValid); end
    endtask

    task automatic test_single_press();
        logic v;
        logic [31:0] d;
        rises = 0;
        press(16'hA5C3);
        checks++;
        if (pending !== 1'b1 || rises !== 1) begin errors++; $display("FAIL single_capture: got pending=%b rises=%0d expected pending=1 rises=1", pending, rises); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b expected 0", overrun); end
        do_read(DATA_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0000_A5C3) begin errors++; $display("FAIL single_data: got v=%b d=%h expected v=1 d=0000a5c3", v, d); end
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL single_clear: got %b expected 0", pending); end
    endtask

    task automatic test_bounce_live();
        logic v, v1, v2;
        logic [31:0] d, d1, d2;
        rises = 0;
        switchInput = 16'h3C3C;
        tick(2);
        for (int i = 0; i < 2; i++) begin
            confirmation = 1'b1;
            tick(2);
            confirmation = 1'b0;
            tick(2);
        end
        tick(10);
        checks++;
        if (pending !== 1'b0 || rises !== 0) begin errors++; $display("FAIL bounce_nocap: got pending=%b rises=%0d expected 0 0", pending, rises); end
        do_read(LIVE_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0000_3C3C) begin errors++; $display("FAIL live_read: got v=%b d=%h expected v=1 d=00003c3c", v, d); end
        do_read(LED_ADDR, v, d);
        checks++;
        if (v !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL unmapped: got v=%b d=%h expected v=0 d=00000000", v, d); end
        // Back-to-back loads on consecutive cycles
        ioRead = 1'b1;
        address = STATUS_ADDR;
        tick(1);
        v1 = readValid;
        d1 = dataIOInput;
        address = LIVE_ADDR;
        tick(1);
        v2 = readValid;
        d2 = dataIOInput;
        ioRead = 1'b0;
        address = 32'h0;
        checks++;
        if (v1 !== 1'b1 || d1 !== 32'h0) begin errors++; $display("FAIL b2b_first: got v=%b d=%h expected v=1 d=00000000", v1, d1); end
        checks++;
        if (v2 !== 1'b1 || d2 !== 32'h0000_3C3C) begin errors++; $display("FAIL b2b_second: got v=%b d=%h expected v=1 d=00003c3c", v2, d2); end
    endtask

    task automatic test_overrun();
        logic v;
        logic [31:0] d;
        press(16'h0001);
        press(16'h0002);
        checks++;
        if ({overrun, pending} !== 2'b11) begin errors++; $display("FAIL ovr_flags: got %b expected 11", {overrun, pending}); end
        do_read(STATUS_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h3) begin errors++; $display("FAIL ovr_status1: got v=%b d=%h expected v=1 d=00000003", v, d); end
        checks++;
        if (overrun !== 1'b0 || pending !== 1'b1) begin errors++; $display("FAIL ovr_clear: got ovr=%b pend=%b expected 0 1", overrun, pending); end
        do_read(DATA_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0000_0002) begin errors++; $display("FAIL ovr_data: got v=%b d=%h expected v=1 d=00000002", v, d); end
        do_read(STATUS_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL ovr_status2: got v=%b d=%h expected v=1 d=00000000", v, d); end
    endtask

    task automatic test_coincident_read();
        logic v;
        logic [31:0] d;
        press(16'h1111);
        switchInput = 16'h2222;
        tick(2);
        confirmation = 1'b1;
        // Capture pulse is registered 7 edges after the button changes; load lands on the next edge
        tick(7);
        ioRead = 1'b1;
        address = DATA_ADDR;
        tick(1);
        ioRead = 1'b0;
        address = 32'h0;
        v = readValid;
        d = dataIOInput;
        checks++;
        if (v !== 1'b1 || d !== 32'h0000_1111) begin errors++; $display("FAIL coinc_data: got v=%b d=%h expected v=1 d=00001111", v, d); end
        checks++;
        if (pending !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL coinc_flags: got pend=%b ovr=%b expected 1 0", pending, overrun); end
        tick(4);
        confirmation = 1'b0;
        tick(10);
        do_read(DATA_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0000_2222) begin errors++; $display("FAIL coinc_new: got v=%b d=%h expected v=1 d=00002222", v, d); end
        checks++;
        if (pending !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL coinc_after: got pend=%b ovr=%b expected 0 0", pending, overrun); end
    endtask

    task automatic test_reset_mid_press();
        logic v;
        logic [31:0] d;
        rises = 0;
        switchInput = 16'h0F0F;
        tick(2);
        confirmation = 1'b1;
        tick(5);
        rst = 1'b1;
        confirmation = 1'b0;
        ioRead = 1'b1;
        address = LIVE_ADDR;
        tick(1);
        rst = 1'b0;
        ioRead = 1'b0;
        address = 32'h0;
        checks++;
        if ({readValid, pending, overrun} !== 3'b000 || dataIOInput !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outs: got v=%b pend=%b ovr=%b d=%h expected all 0", readValid, pending, overrun, dataIOInput);
        end
        tick(12);
        checks++;
        if (pending !== 1'b0 || rises !== 0) begin errors++; $display("FAIL mid_reset_nocap: got pend=%b rises=%0d expected 0 0", pending, rises); end
        press(16'h0F0F);
        checks++;
        if (pending !== 1'b1 || rises !== 1) begin errors++; $display("FAIL mid_reset_recap: got pend=%b rises=%0d expected 1 1", pending, rises); end
        do_read(DATA_ADDR, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0000_0F0F) begin errors++; $display("FAIL mid_reset_data: got v=%b d=%h expected v=1 d=00000f0f", v, d); end
    endtask

    initial begin
        rst = 1'b1;
        switchInput = 16'h0;
        confirmation = 1'b0;
        ioRead = 1'b0;
        address = 32'h0;
        test_reset();
        test_single_press();
        test_bounce_live();
        test_overrun();
        test_coincident_read();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
